// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: display fetch slots, host cell writes and a
// full-buffer clear engine share one single-port RAM, one access per cycle.
module fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int COLS     = 80,
  parameter int ROWS     = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on,
  output logic [2:0]  rgb,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_col,
  input  logic [5:0]  wr_row,
  input  logic [2:0]  wr_data,
  input  logic        clr_start,
  input  logic [2:0]  clr_color,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        wr_err,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [2:0]  mem_wdata,
  input  logic [2:0]  mem_rdata
);

  localparam logic [9:0]  SLOT_H_LIMIT = 10'(H_ACTIVE - 8);
  localparam logic [9:0]  LINE_FETCH_H = 10'(H_TOTAL - 2);
  localparam logic [9:0]  LAST_LINE    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT        = 10'(V_ACTIVE);
  localparam logic [12:0] COLS_A       = 13'(COLS);
  localparam logic [12:0] LAST_ADDR    = 13'(COLS * ROWS - 1);
  localparam logic [6:0]  COLS_W       = 7'(COLS);
  localparam logic [5:0]  ROWS_W       = 6'(ROWS);

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic logic [12:0] cell_addr(input logic [12:0] row, input logic [12:0] col);
    return row * COLS_A + col;
  endfunction

  state_t      state_q, state_d;
  logic [12:0] clr_cnt_q;
  logic [2:0]  clr_color_q;
  logic [2:0]  pixel_q;
  logic        slot_d1_q;

  logic [9:0]  next_line;
  logic        slot_cell, slot_line, slot;
  logic [12:0] slot_addr, host_addr;
  logic        in_range, host_xfer, clear_last;

  // Cell fetch runs two pixels ahead so the colour is registered by the
  // first pixel of the cell; the line-end slot primes column 0 of the next line.
  assign next_line = (vpos == LAST_LINE) ? 10'd0 : vpos + 10'd1;
  assign slot_cell = (hpos[2:0] == 3'd6) && (hpos < SLOT_H_LIMIT);
  assign slot_line = (hpos == LINE_FETCH_H) && (next_line < V_ACT);
  assign slot      = slot_cell || slot_line;
  assign slot_addr = slot_line ? cell_addr(13'(next_line[9:3]), 13'd0)
                               : cell_addr(13'(vpos[9:3]), 13'(hpos[9:3]) + 13'd1);

  assign in_range  = (wr_col < COLS_W) && (wr_row < ROWS_W);
  assign host_addr = cell_addr(13'(wr_row), 13'(wr_col));

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wr_ready   = 1'b0;
    host_xfer  = 1'b0;
    clear_last = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = slot_addr;
    mem_wdata  = clr_color_q;
    unique case (state_q)
      IDLE: begin
        wr_ready  = !slot;
        host_xfer = wr_valid && !slot;
        if (host_xfer && in_range) begin
          mem_we    = 1'b1;
          mem_addr  = host_addr;
          mem_wdata = wr_data;
        end
        if (clr_start) state_d = CLEAR;
      end
      CLEAR: begin
        if (!slot) begin
          mem_we   = 1'b1;
          mem_addr = clr_cnt_q;
          if (clr_cnt_q == LAST_ADDR) begin
            clear_last = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      clr_done    <= 1'b0;
      wr_err      <= 1'b0;
      pixel_q     <= '0;
      slot_d1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_done  <= clear_last;
      slot_d1_q <= slot;
      if (slot_d1_q) pixel_q <= mem_rdata;
      if (host_xfer && !in_range) wr_err <= 1'b1;
      if (state_q == IDLE && clr_start) begin
        clr_cnt_q   <= '0;
        clr_color_q <= clr_color;
      end else if (state_q == CLEAR && !slot) begin
        clr_cnt_q <= clear_last ? 13'd0 : clr_cnt_q + 13'd1;
      end
    end
  end

  assign clr_busy = (state_q == CLEAR);
  assign rgb      = display_on ? pixel_q : 3'b000;

endmodule
